// File: rtl/seg7_frame_encoder.sv
// Recovers hex words from multiplexed 7-segment drive: debounce per digit, decode, assemble a
// frame, present it on valid/ready. Optional SEG7_OVERRUN_EN replaces a pending word instead of stalling.
module seg7_frame_encoder #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     digit_sel,
  output logic [4*DIGITS-1:0]   data_out,
  output logic [DIGITS-1:0]     blank_out,
  output logic                  err_out,
  output logic                  valid_out,
`ifdef SEG7_OVERRUN_EN
  output logic                  overrun_out,
`endif
  input  logic                  ready_in
);

  localparam int unsigned PairW     = DIGITS + 7;
  localparam logic [3:0]  StableCnt = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {StCollect, StPresent, StPresentFull} state_e;

  state_e state_q, state_d;

  logic [PairW-1:0]    pair_q, pair_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shw_q, shw_d, shw_n, data_q, data_d;
  logic [DIGITS-1:0]   shb_q, shb_d, shb_n, blank_q, blank_d;
  logic [DIGITS-1:0]   cap_q, cap_d, cap_n;
  logic                she_q, she_d, she_n, err_q, err_d;
`ifdef SEG7_OVERRUN_EN
  logic                ovr_q, ovr_d;
`endif

  logic       onehot, changed, accept, acc, done, hs, load;
  logic [3:0] dec_nib;
  logic       dec_blank, dec_ill;

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_ill   = 1'b0;
    case (seg_in)
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h67: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      7'h00: dec_blank = 1'b1;
      default: dec_ill = 1'b1;
    endcase
  end

  // Stability qualification: one accept at the moment a run first reaches StableCnt.
  always_comb begin
    pair_d  = {digit_sel, seg_in};
    onehot  = $onehot(digit_sel);
    changed = (pair_d != pair_q);
    if (!onehot) begin
      cnt_d = 4'd0;
    end else if (changed) begin
      cnt_d = 4'd1;
    end else if (cnt_q < StableCnt) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
    accept = onehot && (cnt_d == StableCnt) && (changed || (cnt_q != StableCnt));
  end

  // Handshake and completion; a frozen shadow ignores accepts, so shw_n equals shw_q there.
  always_comb begin
    hs    = valid_out && ready_in;
    acc   = accept && (state_q != StPresentFull);
    shw_n = shw_q;
    shb_n = shb_q;
    she_n = she_q;
    cap_n = cap_q;
    if (acc) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (digit_sel[i]) begin
          shw_n[4*i +: 4] = dec_nib;
          shb_n[i]        = dec_blank;
        end
      end
      she_n = she_q | dec_ill;
      cap_n = cap_q | digit_sel;
    end
    done = &cap_n;
`ifdef SEG7_OVERRUN_EN
    load  = done;
    ovr_d = done && (state_q == StPresent) && !hs;
`else
    load  = done && ((state_q == StCollect) || hs);
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StCollect: begin
        if (done) state_d = StPresent;
      end
      StPresent: begin
        if (hs) begin
          state_d = done ? StPresent : StCollect;
        end else if (done) begin
`ifdef SEG7_OVERRUN_EN
          state_d = StPresent;
`else
          state_d = StPresentFull;
`endif
        end
      end
      StPresentFull: begin
        if (hs) state_d = StPresent;
      end
      default: state_d = StCollect;
    endcase
  end

  always_comb begin
    shw_d   = shw_n;
    shb_d   = shb_n;
    she_d   = she_n;
    cap_d   = cap_n;
    data_d  = data_q;
    blank_d = blank_q;
    err_d   = err_q;
    if (load) begin
      data_d  = shw_n;
      blank_d = shb_n;
      err_d   = she_n;
      cap_d   = '0;
      she_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StCollect;
      pair_q  <= '0;
      cnt_q   <= 4'd0;
      shw_q   <= '0;
      shb_q   <= '0;
      she_q   <= 1'b0;
      cap_q   <= '0;
      data_q  <= '0;
      blank_q <= '0;
      err_q   <= 1'b0;
`ifdef SEG7_OVERRUN_EN
      ovr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      cnt_q   <= cnt_d;
      shw_q   <= shw_d;
      shb_q   <= shb_d;
      she_q   <= she_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      blank_q <= blank_d;
      err_q   <= err_d;
`ifdef SEG7_OVERRUN_EN
      ovr_q   <= ovr_d;
`endif
    end
  end

  always_comb begin
    valid_out   = (state_q != StCollect);
    data_out    = data_q;
    blank_out   = blank_q;
    err_out     = err_q;
`ifdef SEG7_OVERRUN_EN
    overrun_out = ovr_q;
`endif
  end

endmodule

// File: doc/seg7_frame_encoder.md
Name: seg7_frame_encoder

Overview:
Receive side of the team's 7-segment display path: converts multiplexed 7-segment drive (segment lines plus one-hot digit strobe) back into hex nibbles. Each digit's pattern is qualified for stability, then decoded. A complete multi-digit word is assembled per scan frame. The word is presented on a valid/ready handshake. Used in the bench/monitor side and in loopback self-check of the display driver.

Parameters:
DIGITS, 4, number of multiplexed digits per frame (1..8)
STABLE_CYCLES, 2, consecutive identical samples required to accept a digit (1..15)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
seg_in  input  7  segment pattern, bit6=g .. bit0=a, 1 = segment lit
digit_sel  input  DIGITS  one-hot digit strobe; bit i selects digit i (digit 0 = least significant nibble)
data_out  output  4*DIGITS  decoded word, nibble i at bits [4i+3:4i]
blank_out  output  DIGITS  bit i set if digit i was blank (seg_in = 0)
err_out  output  1  set if any digit in the presented word had an illegal pattern
valid_out  output  1  data_out/blank_out/err_out valid
ready_in  input  1  consumer accepts word when valid_out && ready_in

Behaviour:
- Reset: all outputs 0, shadow word/blank/err cleared, captured mask 0, stability counter 0. Reset is asynchronous; it aborts any partial frame or pending word.
- Sampling: the {digit_sel, seg_in} pair is registered every cycle.
- Stability counter: increments, saturating at STABLE_CYCLES, while the current pair equals the previous pair. It is reset to 1 on a change.
- Non-one-hot digit_sel (zero or multiple bits): never accepted; counter forced to 0.
- Accept: occurs on the cycle the counter reaches STABLE_CYCLES; exactly one accept per stable run.
  - Decode seg_in to the nibble and write it into shadow slot i.
  - Set captured[i] and write blank[i].
  - OR the illegal flag into shadow err.
  - A re-accept of a digit already captured in the frame overwrites its slot; the captured mask is unchanged.
- Decode table (seg_in hex -> nibble):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 67->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F
  - 00 -> nibble 0 with blank set.
  - Any other pattern -> nibble 0, illegal flag set.
- Frame complete: captured mask all ones.
- FSM:
  - COLLECT: frame incomplete, output slot empty.
  - PRESENT: valid_out=1, waiting for ready_in.
  - PRESENT_FULL: valid_out=1 and the next frame is complete in the shadow.
- Transitions:
  - COLLECT -> PRESENT: on frame complete. Shadow is copied to outputs; valid_out rises the next cycle (1-cycle latency from final accept); captured mask and shadow err are cleared.
  - PRESENT -> COLLECT: on valid_out && ready_in; valid_out falls the next cycle. Collection of the next frame continues during PRESENT.
  - PRESENT -> PRESENT_FULL: next frame completes while the handshake is pending. The shadow is frozen; further accepts are ignored.
  - PRESENT_FULL -> PRESENT: on handshake. Shadow is copied to outputs; valid_out stays 1; captured mask cleared.
- Final accept coinciding with the handshake in PRESENT: treated as handshake then complete. Outputs load the new frame and valid_out stays 1.
- Outputs are stable while valid_out=1 and ready_in=0.

Optional Feature:
SEG7_OVERRUN_EN:
- Defined: adds output port overrun_out (1 bit, reset 0). A frame completing while valid_out=1 and no handshake replaces data_out/blank_out/err_out immediately (next cycle). valid_out stays 1, overrun_out pulses high for 1 cycle, and PRESENT_FULL is unused. Collection never stalls.
- Undefined: no overrun_out port; stall behaviour via PRESENT_FULL as above.

Test Plan:
1. Reset, STABLE_CYCLES=2, ready_in=1. Drive digits 0..3 with 4F,5B,06,3F for 3 cycles each. -> data_out=16'h0123, blank_out=0, err_out=0, valid_out high 1 cycle after the digit-3 accept.
2. Digit 2 pattern held only 1 cycle then changed; digit_sel=4'b0101 driven for 5 cycles. -> no accept in either case, valid_out stays 0 until digit 2 is stable for 2 cycles.
3. Digit 1 = 7'h00, digit 3 = 7'h2A, others legal. -> blank_out=4'b0010, nibbles 1 and 3 = 0, err_out=1.
4. ready_in=0 while two full frames (h1111, h2222) arrive, then ready_in=1. -> h1111 held stable, then h2222 presented with valid_out continuously high. Frames arriving while PRESENT_FULL are ignored.
5. With SEG7_OVERRUN_EN, same stimulus as 4. -> data_out switches to h2222 without handshake, overrun_out pulses 1 cycle.
6. rst asserted asynchronously mid-frame and mid-PRESENT. -> all outputs 0 immediately; a full new frame is required before the next valid_out.
